// File: rtl/pipe_stage_chain.sv
// Elastic chain of STAGES valid/ready pipeline registers with per-stage flush,
// optional kill-younger propagation, bubble collapsing and a saturating drop counter.
module pipe_stage_chain #(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STAGES       = 4,
    parameter bit          KILL_YOUNGER = 1'b0,
    parameter int unsigned CNT_W        = 16,
    localparam int unsigned OCC_W       = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic [STAGES-1:0] flush,
    output logic [STAGES-1:0] stage_valid,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int unsigned SUM_W = CNT_W + OCC_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [STAGES-1:0] v_q, v_d;
    logic [DATA_W-1:0] d_q [STAGES];
    logic [DATA_W-1:0] d_d [STAGES];
    logic [CNT_W-1:0]  drop_q, drop_d;

    logic [STAGES:0]   rdy_ext;
    logic [STAGES:0]   kill_ext;
    logic [STAGES-1:0] src_v;
    logic [DATA_W-1:0] src_d [STAGES];
    logic [STAGES-1:0] keep;
    logic [STAGES-1:0] dropped;
    logic [OCC_W-1:0]  ndrop;
    logic [OCC_W-1:0]  occ_cnt;
    logic [SUM_W-1:0]  drop_sum;

    always_comb begin
        rdy_ext  = '0;
        kill_ext = '0;
        // Walk from the output end so each stage sees its successor's ready/kill.
        rdy_ext[STAGES]  = out_ready;
        kill_ext[STAGES] = 1'b0;
        for (int unsigned j = 0; j < STAGES; j++) begin
            rdy_ext[STAGES-1-j]  = !v_q[STAGES-1-j] || rdy_ext[STAGES-j];
            kill_ext[STAGES-1-j] = flush[STAGES-1-j] || (KILL_YOUNGER && kill_ext[STAGES-j]);
        end

        src_v    = '0;
        src_v[0] = in_valid;
        src_d[0] = in_data;
        for (int unsigned i = 1; i < STAGES; i++) begin
            src_v[i] = v_q[i-1];
            src_d[i] = d_q[i-1];
        end

        keep    = '0;
        dropped = '0;
        v_d     = '0;
        ndrop   = '0;
        occ_cnt = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            // keep = the beat that would occupy stage i after the edge, before any kill
            keep[i]    = rdy_ext[i] ? src_v[i] : v_q[i];
            dropped[i] = keep[i] && kill_ext[i];
            v_d[i]     = keep[i] && !kill_ext[i];
            d_d[i]     = (rdy_ext[i] && src_v[i]) ? src_d[i] : d_q[i];
            ndrop      = ndrop + OCC_W'(dropped[i]);
            occ_cnt    = occ_cnt + OCC_W'(v_q[i]);
        end

        drop_sum = SUM_W'(drop_q) + SUM_W'(ndrop);
        drop_d   = (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_q    <= '0;
            drop_q <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q    <= v_d;
            drop_q <= drop_d;
            d_q    <= d_d;
        end
    end

    assign in_ready    = rdy_ext[0];
    assign out_valid   = v_q[STAGES-1];
    assign out_data    = d_q[STAGES-1];
    assign stage_valid = v_q;
    assign occupancy   = occ_cnt;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: keep-mode (u0), kill-younger (u1) and a
// 2-bit drop counter (u2) instance share one stimulus stream.
module tb_pipe_stage_chain;

    localparam int DW = 64;
    localparam int ST = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic          in_valid;
    logic          out_ready;
    logic [DW-1:0] in_data;
    logic [ST-1:0] flush;

    logic          rdy0, ov0, rdy1, ov1, rdy2, ov2;
    logic [DW-1:0] od0, od1, od2;
    logic [ST-1:0] sv0, sv1, sv2;
    logic [2:0]    occ0, occ1, occ2;
    logic [15:0]   dc0, dc1;
    logic [1:0]    dc2;

    int errors = 0;
    int checks = 0;

    pipe_stage_chain #(.DATA_W(DW), .STAGES(ST), .KILL_YOUNGER(1'b0), .CNT_W(16)) u0 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .flush(flush),
        .stage_valid(sv0), .occupancy(occ0), .drop_cnt(dc0));

    pipe_stage_chain #(.DATA_W(DW), .STAGES(ST), .KILL_YOUNGER(1'b1), .CNT_W(16)) u1 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .flush(flush),
        .stage_valid(sv1), .occupancy(occ1), .drop_cnt(dc1));

    pipe_stage_chain #(.DATA_W(DW), .STAGES(ST), .KILL_YOUNGER(1'b0), .CNT_W(2)) u2 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .flush(flush),
        .stage_valid(sv2), .occupancy(occ2), .drop_cnt(dc2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = '0; in_data = '0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic fill(input logic [DW-1:0] base);
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < ST; i++) begin
            in_data = base + DW'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = '0; in_data = '0;
        #12;
        checks++; if ({ov0, od0, sv0, occ0, dc0} !== '0) begin errors++; $display("FAIL reset_u0_state: got ov=%0b od=%h sv=%b occ=%0d dc=%0d expected all zero", ov0, od0, sv0, occ0, dc0); end
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", rdy0); end
        checks++; if ({ov1, od1, sv1, occ1, dc1, ov2, od2, sv2, occ2, dc2} !== '0) begin errors++; $display("FAIL reset_u1_u2_state: not all zero"); end
        checks++; if ({rdy1, rdy2} !== 2'b11) begin errors++; $display("FAIL reset_u1_u2_ready: got %b expected 11", {rdy1, rdy2}); end
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int t = 0; t < 13; t++) begin
            in_valid = (t < 8);
            in_data  = DW'(t + 1);
            #1;
            checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL stream_ready t=%0d: got %0b expected 1", t, rdy0); end
            checks++; if (ov0 !== ((t >= 4) && (t <= 11))) begin errors++; $display("FAIL stream_valid t=%0d: got %0b expected %0b", t, ov0, (t >= 4) && (t <= 11)); end
            if (t >= 4 && t <= 11) begin
                checks++; if (od0 !== DW'(t - 3)) begin errors++; $display("FAIL stream_data t=%0d: got %h expected %h", t, od0, DW'(t - 3)); end
            end
            if (t >= 4 && t <= 8) begin
                checks++; if (occ0 !== 3'd4) begin errors++; $display("FAIL stream_occ t=%0d: got %0d expected 4", t, occ0); end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_fill_passthrough();
        logic [DW-1:0] expv [4];
        expv[0] = DW'('h11); expv[1] = DW'('h12); expv[2] = DW'('h13); expv[3] = DW'('h20);
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int t = 0; t < 6; t++) begin
            in_data = DW'('h10 + t);
            #1;
            checks++; if (rdy0 !== (t < 4)) begin errors++; $display("FAIL fill_ready t=%0d: got %0b expected %0b", t, rdy0, t < 4); end
            tick();
        end
        checks++; if (sv0 !== 4'b1111 || occ0 !== 3'd4) begin errors++; $display("FAIL fill_full: got sv=%b occ=%0d expected 1111/4", sv0, occ0); end
        checks++; if ({ov0, od0} !== {1'b1, DW'('h10)}) begin errors++; $display("FAIL fill_head: got %0b/%h expected 1/10", ov0, od0); end
        in_data = DW'('h20); out_ready = 1'b1;
        #1;
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL passthrough_ready: got %0b expected 1", rdy0); end
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if ({ov0, od0} !== {1'b1, expv[k]}) begin errors++; $display("FAIL passthrough_order k=%0d: got %0b/%h expected 1/%h", k, ov0, od0, expv[k]); end
            tick();
        end
    endtask

    task automatic test_bubbles();
        do_reset();
        out_ready = 1'b0;
        for (int t = 0; t < 7; t++) begin
            in_valid = (t % 2 == 0);
            in_data  = DW'('hA0 + t);
            tick();
        end
        in_valid = 1'b0;
        checks++; if (sv0 !== 4'b1111 || occ0 !== 3'd4) begin errors++; $display("FAIL bubble_collapse: got sv=%b occ=%0d expected 1111/4", sv0, occ0); end
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL bubble_full_ready: got %0b expected 0", rdy0); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if ({ov0, od0} !== {1'b1, DW'('hA0 + 2 * k)}) begin errors++; $display("FAIL bubble_order k=%0d: got %0b/%h expected 1/%h", k, ov0, od0, DW'('hA0 + 2 * k)); end
            tick();
        end
        checks++; if (sv0 !== 4'b0000) begin errors++; $display("FAIL bubble_drained: got %b expected 0000", sv0); end
    endtask

    task automatic test_flush_keep();
        logic [DW-1:0] got [4];
        int n;
        got[0] = '0; got[1] = '0; got[2] = '0; got[3] = '0;
        n = 0;
        do_reset();
        fill(DW'('h31));
        flush = 4'b0100;
        #1;
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL flush_ready_indep: got %0b expected 0", rdy0); end
        tick();
        flush = '0;
        checks++; if (sv0 !== 4'b1011 || occ0 !== 3'd3) begin errors++; $display("FAIL flush_keep_sv: got sv=%b occ=%0d expected 1011/3", sv0, occ0); end
        checks++; if (dc0 !== 16'd1) begin errors++; $display("FAIL flush_keep_drop: got %0d expected 1", dc0); end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (ov0 === 1'b1 && n < 4) begin got[n] = od0; n++; end
            tick();
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL flush_keep_count: got %0d beats expected 3", n); end
        checks++; if (got[0] !== DW'('h31) || got[1] !== DW'('h33) || got[2] !== DW'('h34)) begin errors++; $display("FAIL flush_keep_order: got %h %h %h expected 31 33 34", got[0], got[1], got[2]); end
    endtask

    task automatic test_kill_younger();
        do_reset();
        fill(DW'('h41));
        in_valid = 1'b1; in_data = DW'('h99); out_ready = 1'b1; flush = 4'b0100;
        #1;
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL ky_ready: got %0b expected 1", rdy1); end
        checks++; if ({ov1, od1} !== {1'b1, DW'('h41)}) begin errors++; $display("FAIL ky_delivered: got %0b/%h expected 1/41", ov1, od1); end
        tick();
        flush = '0; in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (sv1 !== 4'b1000 || occ1 !== 3'd1) begin errors++; $display("FAIL ky_sv: got sv=%b occ=%0d expected 1000/1", sv1, occ1); end
        checks++; if (dc1 !== 16'd3) begin errors++; $display("FAIL ky_drop: got %0d expected 3", dc1); end
        checks++; if (od1 !== DW'('h42)) begin errors++; $display("FAIL ky_survivor: got %h expected 42", od1); end
        checks++; if (sv0 !== 4'b1011 || dc0 !== 16'd1) begin errors++; $display("FAIL ky_keepmode_ref: got sv=%b dc=%0d expected 1011/1", sv0, dc0); end
    endtask

    task automatic test_saturate();
        logic [ST-1:0] fl [4];
        logic          iv [4];
        logic [1:0]    e2 [4];
        logic [15:0]   e0 [4];
        fl[0] = 4'b0001; fl[1] = 4'b0110; fl[2] = 4'b1000; fl[3] = 4'b0001;
        iv[0] = 1'b0;    iv[1] = 1'b0;    iv[2] = 1'b0;    iv[3] = 1'b1;
        e2[0] = 2'd1;    e2[1] = 2'd3;    e2[2] = 2'd3;    e2[3] = 2'd3;
        e0[0] = 16'd1;   e0[1] = 16'd3;   e0[2] = 16'd4;   e0[3] = 16'd5;
        do_reset();
        fill(DW'('h51));
        for (int k = 0; k < 4; k++) begin
            flush = fl[k]; in_valid = iv[k]; in_data = DW'('h5A);
            tick();
            checks++; if (dc2 !== e2[k]) begin errors++; $display("FAIL sat_cnt2 k=%0d: got %0d expected %0d", k, dc2, e2[k]); end
            checks++; if (dc0 !== e0[k]) begin errors++; $display("FAIL sat_cnt16 k=%0d: got %0d expected %0d", k, dc0, e0[k]); end
        end
        flush = '0; in_valid = 1'b0;
        checks++; if (sv2 !== 4'b0000) begin errors++; $display("FAIL sat_empty: got %b expected 0000", sv2); end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_data = DW'('h60); flush = 4'b0001;
        tick();
        flush = '0;
        for (int t = 0; t < 5; t++) begin
            in_data = DW'('h61 + t);
            tick();
        end
        checks++; if (dc0 !== 16'd1 || ov0 !== 1'b1) begin errors++; $display("FAIL midstream_state: got dc=%0d ov=%0b expected 1/1", dc0, ov0); end
        #2;
        rstn = 1'b0;
        #1;
        checks++; if ({ov0, od0, sv0, occ0, dc0, dc2} !== '0) begin errors++; $display("FAIL async_reset_state: got ov=%0b od=%h sv=%b occ=%0d dc=%0d dc2=%0d expected zero", ov0, od0, sv0, occ0, dc0, dc2); end
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL async_reset_ready: got %0b expected 1", rdy0); end
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_passthrough();
        test_bubbles();
        test_flush_keep();
        test_kill_younger();
        test_saturate();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
